conv_output_writer: RTL and testbench

// - Write-back stage downstream of the convolution controller/datapath.
// - Consumes one 1-bit thresholded convolution result per valid cycle.
// - Packs results LSB-first into DATA_W-bit words, one output row at a time.
// - Writes packed words to output SRAM at consecutive addresses from BASE_ADDR.
// - Flushes partial words at row end and at frame end, then reports completion.

---
 rtl/conv_output_writer.sv | 165 ++++++++++++++++
 tb/tb_conv_output_writer.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/conv_output_writer.sv
`default_nettype none
// ============================================================================
// Module      : conv_output_writer
// Description : Write-back stage for the convolution engine. Packs 1-bit
//               thresholded results LSB-first into DATA_W-bit words, one
//               output row at a time. Writes each word to the output SRAM at
//               consecutive addresses starting at BASE_ADDR. Flushes partial
//               words at row end and at frame end, then pulses done.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk                     in   1       clock, rising edge
//   reset_b                 in   1       asynchronous reset, active-low
//   start                   in   1       begins a frame (honoured in IDLE only)
//   res_valid               in   1       res_bit is valid this cycle
//   res_bit                 in   1       convolution result bit
//   row_end                 in   1       this cycle closes the current row
//   frame_done              in   1       last row complete; flush and finish
//   dut_sram_write_enable   out  1       output SRAM write strobe
//   dut_sram_write_address  out  ADDR_W  output SRAM write address
//   dut_sram_write_data     out  DATA_W  output SRAM write data
//   busy                    out  1       high from start acceptance until done
//   done                    out  1       1-cycle pulse, frame fully written
//   words_written           out  ADDR_W  writes issued this frame
// ============================================================================
module conv_output_writer #(
   parameter int                DATA_W    = 16,
   parameter int                ADDR_W    = 12,
   parameter logic [ADDR_W-1:0] BASE_ADDR = 12'h000,
   parameter int                CNT_W     = 5
) (
   input  logic              clk,
   input  logic              reset_b,
   input  logic              start,
   input  logic              res_valid,
   input  logic              res_bit,
   input  logic              row_end,
   input  logic              frame_done,
   output logic              dut_sram_write_enable,
   output logic [ADDR_W-1:0] dut_sram_write_address,
   output logic [DATA_W-1:0] dut_sram_write_data,
   output logic              busy,
   output logic              done,
   output logic [ADDR_W-1:0] words_written
);

   localparam logic [CNT_W-1:0]  c_LAST_POS = CNT_W'(DATA_W - 1);
   localparam logic [CNT_W-1:0]  c_CNT_ONE  = CNT_W'(1);
   localparam logic [DATA_W-1:0] c_BIT_ONE  = DATA_W'(1);
   localparam logic [ADDR_W-1:0] c_ADDR_ONE = ADDR_W'(1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_RUN   = 2'd1,
      S_FLUSH = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   state_t            r_state;
   logic [DATA_W-1:0] r_pack;
   logic [CNT_W-1:0]  r_cnt;
   logic [ADDR_W-1:0] r_ptr;
   logic              r_we;
   logic [ADDR_W-1:0] r_addr;
   logic [DATA_W-1:0] r_data;
   logic              r_busy;
   logic              r_done;
   logic [ADDR_W-1:0] r_ww;

   logic [DATA_W-1:0] w_bit_set;
   logic [DATA_W-1:0] w_pack_upd;
   logic [CNT_W-1:0]  w_cnt_upd;
   logic              w_complete;

   // Pack register and bit count as they stand after accepting this cycle's bit.
   assign w_bit_set  = (res_valid && res_bit) ? (c_BIT_ONE << r_cnt) : '0;
   assign w_pack_upd = r_pack | w_bit_set;
   assign w_cnt_upd  = res_valid ? (r_cnt + c_CNT_ONE) : r_cnt;

   // A word closes when it fills, when a row ends on it, or when the frame
   // ends with bits still outstanding. The frame-end case launches the flush
   // write on the edge that enters FLUSH, so the write is visible during the
   // FLUSH cycle and done follows one cycle later.
   assign w_complete = (res_valid && ((r_cnt == c_LAST_POS) || row_end))
                     || (!res_valid && row_end && (r_cnt != '0))
                     || (frame_done && (w_cnt_upd != '0));

   always_ff @(posedge clk or negedge reset_b) begin
      if (!reset_b) begin
         r_state <= S_IDLE;
         r_pack  <= '0;
         r_cnt   <= '0;
         r_ptr   <= '0;
         r_we    <= 1'b0;
         r_addr  <= '0;
         r_data  <= '0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
         r_ww    <= '0;
      end else begin
         r_we   <= 1'b0;
         r_done <= 1'b0;

         // Count a write once its strobe cycle has passed.
         if (r_we) begin
            r_ww <= r_ww + c_ADDR_ONE;
         end

         case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_state <= S_RUN;
                  r_ptr   <= BASE_ADDR;
                  r_ww    <= '0;
                  r_busy  <= 1'b1;
                  r_pack  <= '0;
                  r_cnt   <= '0;
               end
            end

            S_RUN: begin
               if (w_complete) begin
                  r_we   <= 1'b1;
                  r_addr <= r_ptr;
                  r_data <= w_pack_upd;
                  r_ptr  <= r_ptr + c_ADDR_ONE;
                  r_pack <= '0;
                  r_cnt  <= '0;
               end else begin
                  r_pack <= w_pack_upd;
                  r_cnt  <= w_cnt_upd;
               end
               if (frame_done) begin
                  r_state <= S_FLUSH;
               end
            end

            S_FLUSH: begin
               r_state <= S_DONE;
               r_busy  <= 1'b0;
               r_done  <= 1'b1;
               r_pack  <= '0;
               r_cnt   <= '0;
            end

            S_DONE: begin
               r_state <= S_IDLE;
            end

            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   assign dut_sram_write_enable  = r_we;
   assign dut_sram_write_address = r_addr;
   assign dut_sram_write_data    = r_data;
   assign busy                   = r_busy;
   assign done                   = r_done;
   assign words_written          = r_ww;

endmodule
`default_nettype wire

// File: tb/tb_conv_output_writer.sv
`default_nettype none
// ============================================================================
// Module      : tb_conv_output_writer
// Description : Self-checking bench for conv_output_writer. A bit-level
//               model tracks the word being assembled and predicts every
//               output; a negedge process compares DUT against it each
//               cycle. Hand-computed literals pin the key write values.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_conv_output_writer;

   localparam int DATA_W = 16;
   localparam int ADDR_W = 12;
   localparam int BASE   = 0;

   logic              clk = 1'b0;
   logic              reset_b;
   logic              start;
   logic              res_valid;
   logic              res_bit;
   logic              row_end;
   logic              frame_done;
   logic              we;
   logic [ADDR_W-1:0] waddr;
   logic [DATA_W-1:0] wdata;
   logic              busy;
   logic              done;
   logic [ADDR_W-1:0] ww;

   conv_output_writer #(
      .DATA_W    (DATA_W),
      .ADDR_W    (ADDR_W),
      .BASE_ADDR (12'h000),
      .CNT_W     (5)
   ) u_dut (
      .clk                    (clk),
      .reset_b                (reset_b),
      .start                  (start),
      .res_valid              (res_valid),
      .res_bit                (res_bit),
      .row_end                (row_end),
      .frame_done             (frame_done),
      .dut_sram_write_enable  (we),
      .dut_sram_write_address (waddr),
      .dut_sram_write_data    (wdata),
      .busy                   (busy),
      .done                   (done),
      .words_written          (ww)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_pass   = 0;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s @%0t: got %0h expected %0h", nm, $time, act, exp);
   endtask

   // ---------------- behavioural model ----------------
   int exp_we = 0, exp_addr = 0, exp_data = 0, exp_busy = 0, exp_done = 0, exp_ww = 0;
   int m_in_frame = 0, m_tail = 0, m_word = 0, m_n = 0, m_ptr = 0;

   initial forever begin
      @(posedge clk or negedge reset_b);
      if (!reset_b) begin
         exp_we = 0; exp_addr = 0; exp_data = 0; exp_busy = 0; exp_done = 0; exp_ww = 0;
         m_in_frame = 0; m_tail = 0; m_word = 0; m_n = 0; m_ptr = 0;
      end else begin
         if (exp_we != 0) exp_ww = (exp_ww + 1) % 4096;
         exp_we   = 0;
         exp_done = 0;
         if (m_in_frame == 0) begin
            if (start) begin
               m_in_frame = 1; exp_busy = 1; m_ptr = BASE; exp_ww = 0; m_word = 0; m_n = 0;
            end
         end else if (m_tail == 1) begin
            exp_done = 1; exp_busy = 0; m_tail = 2;
         end else if (m_tail == 2) begin
            m_in_frame = 0; m_tail = 0;
         end else begin
            if (res_valid) begin
               m_word = m_word + (int'(res_bit) << m_n);
               m_n    = m_n + 1;
            end
            if (m_n == DATA_W || ((row_end || frame_done) && m_n > 0)) begin
               exp_we = 1; exp_addr = m_ptr; exp_data = m_word;
               m_ptr = (m_ptr + 1) % 4096; m_word = 0; m_n = 0;
            end
            if (frame_done) m_tail = 1;
         end
      end
   end

   // ---------------- per-cycle compare + write log ----------------
   int cyc = 0;
   int wlog_a[$];
   int wlog_d[$];
   int wlog_c[$];
   int done_cyc = -1;

   initial forever begin
      @(posedge clk);
      cyc++;
   end

   initial forever begin
      @(negedge clk);
      check("we",    32'(we),    exp_we);
      check("addr",  32'(waddr), exp_addr);
      check("data",  32'(wdata), exp_data);
      check("busy",  32'(busy),  exp_busy);
      check("done",  32'(done),  exp_done);
      check("words", 32'(ww),    exp_ww);
      if (we === 1'b1) begin
         wlog_a.push_back(int'(waddr));
         wlog_d.push_back(int'(wdata));
         wlog_c.push_back(cyc);
      end
      if (done === 1'b1) done_cyc = cyc;
   end

   function automatic int get_a(input int i);
      return (i < wlog_a.size()) ? wlog_a[i] : -1;
   endfunction
   function automatic int get_d(input int i);
      return (i < wlog_d.size()) ? wlog_d[i] : -1;
   endfunction
   function automatic int get_c(input int i);
      return (i < wlog_c.size()) ? wlog_c[i] : -1;
   endfunction

   // ---------------- stimulus ----------------
   task automatic drive(input logic v, input logic b, input logic re, input logic fd, input logic st);
      res_valid  = v;
      res_bit    = b;
      row_end    = re;
      frame_done = fd;
      start      = st;
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
   endtask

   int base;

   initial begin
      reset_b = 1'b0;
      start = 1'b0; res_valid = 1'b0; res_bit = 1'b0; row_end = 1'b0; frame_done = 1'b0;

      // Random activity while held in reset must not disturb the outputs.
      for (int i = 0; i < 6; i++) begin
         start      = 1'($urandom);
         res_valid  = 1'($urandom);
         res_bit    = 1'($urandom);
         row_end    = 1'($urandom);
         frame_done = 1'($urandom);
         @(posedge clk);
         #1;
      end
      start = 1'b0; res_valid = 1'b0; res_bit = 1'b0; row_end = 1'b0; frame_done = 1'b0;
      reset_b = 1'b1;
      idle(4);
      check("lit_no_wr_idle", wlog_d.size(), 0);
      check("lit_busy_idle", 32'(busy), 0);

      // Full word: 1,0,1,0,... -> 0x5555 @0x000
      base = wlog_d.size();
      drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      for (int i = 0; i < 16; i++) drive(1'b1, 1'((i % 2) == 0), 1'b0, 1'b0, 1'b0);
      idle(2);
      check("lit_full_cnt",  wlog_d.size() - base, 1);
      check("lit_full_data", get_d(base), 32'h5555);
      check("lit_full_addr", get_a(base), 0);
      check("lit_full_ww",   32'(ww), 1);
      drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      idle(4);

      // Short row 1,1,0,0,1,1 -> 0x0033, next row's first bit at bit 0
      base = wlog_d.size();
      drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
      drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
      idle(2);
      check("lit_short_data", get_d(base), 32'h0033);
      check("lit_short_addr", get_a(base), 0);
      check("lit_next_data",  get_d(base + 1), 32'h0001);
      check("lit_next_addr",  get_a(base + 1), 1);
      drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      idle(4);

      // Long row: 20 ones -> 0xFFFF @0, 0x000F @1; lone row_end is a no-op;
      // then three one-bit rows give back-to-back writes.
      base = wlog_d.size();
      drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      for (int i = 0; i < 20; i++) drive(1'b1, 1'b1, 1'(i == 19), 1'b0, 1'b0);
      drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
      drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
      drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
      idle(2);
      check("lit_long_cnt",   wlog_d.size() - base, 5);
      check("lit_long_d0",    get_d(base), 32'hFFFF);
      check("lit_long_d1",    get_d(base + 1), 32'h000F);
      check("lit_long_a1",    get_a(base + 1), 1);
      check("lit_b2b_a4",     get_a(base + 4), 4);
      check("lit_b2b_gap",    get_c(base + 4) - get_c(base + 2), 2);
      drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      idle(4);

      // Frame flush: 1,0,1 then frame_done -> 0x0005, done one cycle later
      base = wlog_d.size();
      drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      idle(4);
      check("lit_flush_data", get_d(base), 32'h0005);
      check("lit_flush_addr", get_a(base), 0);
      check("lit_done_lag",   done_cyc - get_c(base), 1);
      check("lit_flush_ww",   32'(ww), 1);

      // Abort: reset lands in the cycle that would complete a full word
      base = wlog_d.size();
      drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      for (int i = 0; i < 15; i++) drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      res_valid = 1'b1; res_bit = 1'b1;
      #3;
      reset_b = 1'b0;
      @(posedge clk);
      #1;
      res_valid = 1'b0; res_bit = 1'b0;
      @(posedge clk);
      #1;
      reset_b = 1'b1;
      idle(2);
      check("lit_abort_nowr", wlog_d.size() - base, 0);
      drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      for (int i = 0; i < 16; i++) drive(1'b1, 1'(i >= 8), 1'b0, 1'b0, 1'b0);
      idle(2);
      check("lit_restart_addr", get_a(base), 0);
      check("lit_restart_data", get_d(base), 32'hFF00);
      check("lit_restart_ww",   32'(ww), 1);
      drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      idle(4);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
`default_nettype wire
